keypad_row_debouncer: RTL
=========================

Name: keypad_row_debouncer

Overview:
- Parametrised successor to the single-bit row synchronizer in the hex keypad scanner.
- Synchronizes each keypad row line independently through an N-stage flop chain, then debounces it with a per-row counter.
- Presents a stable row vector, an encoded row index, a multi-press flag and one-cycle press/release pulses to the scanner FSM and the encoder.

Parameters:
- NUM_ROWS, 4, number of row inputs (>=1).
- SYNC_STAGES, 2, synchronizer flops per row (>=2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized change must persist before acceptance (>=1).
- ACTIVE_HIGH, 1, row input polarity; 0 means rows are active-low and are inverted before the synchronizer.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- row  input  NUM_ROWS  asynchronous raw row lines from the keypad.
- row_stable  output  NUM_ROWS  debounced, active-high row state.
- key_active  output  1  OR of row_stable.
- row_idx  output  IDX_W  index of the lowest set bit of row_stable; 0 when none. IDX_W = max(1, clog2(NUM_ROWS)).
- multi_row  output  1  high when more than one row_stable bit is set.
- press_pulse  output  1  one-cycle pulse on a key_active 0->1 transition.
- release_pulse  output  1  one-cycle pulse on a key_active 1->0 transition.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) clears:
  - all synchronizer flops, per-row counters, row_stable and the key_active history flop;
  - therefore all outputs are 0 in the following cycle.
- Reset overrides every other event, including a counter about to expire.
- Reset never produces press_pulse or release_pulse.
- Normalization: rn[i] = ACTIVE_HIGH ? row[i] : ~row[i].
- Synchronizer:
  - rn[i] feeds a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
  - No logic between stages.
- Debounce, per row i, each edge:
  - If sync[i] == row_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: row_stable[i] <= sync[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- Latency:
  - A clean level change on row[i] updates row_stable[i] at rising edge number SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new level as edge 1.
  - With defaults this is edge 18.
- Glitch rejection:
  - Any return of sync[i] to row_stable[i] before expiry clears cnt[i].
  - row_stable[i] does not change, and no pulse is produced.
- Rows are fully independent; counters run concurrently.
- key_active, row_idx and multi_row are combinational decodes of the row_stable registers and add no latency.
- press_pulse = key_active & ~key_active_q, and release_pulse = ~key_active & key_active_q, where key_active_q is key_active registered.
  - Each is high for exactly one cycle, in the cycle following the row_stable update edge.
- Simultaneous events:
  - Several rows accepted on the same edge give one press_pulse; multi_row asserts that same cycle.
  - A row released while another stays held gives no pulses; row_idx and multi_row update.
  - A press on one row and a release on another on the same edge, with key_active staying 1, gives no pulses.
- Reset mid-debounce discards partial counts.
- A row held through reset deassertion is re-acquired: row_stable sets SYNC_STAGES+DEBOUNCE_CYCLES edges after the first non-reset edge, followed by press_pulse.

Test Plan:
1. Reset, then row=4'b0000 for 50 cycles -> all outputs stay 0; no pulses.
2. Defaults; row goes 4'b0000->4'b0100 and is held.
   - row_stable=4'b0100 after edge 18.
   - key_active=1, row_idx=2, multi_row=0.
   - press_pulse high exactly 1 cycle.
   - Then row=4'b0000 -> release_pulse 1 cycle, 18 edges later.
3. Glitch: row[1] high for 10 cycles, then low for 3, repeated 5 times -> row_stable remains 0; no pulses; cnt[1] returns to 0 after each low gap.
4. row=4'b1001 applied in one step -> row_stable=4'b1001 on the same edge, row_idx=0, multi_row=1, single press_pulse. Then row[0] released -> row_idx=3, multi_row=0, no pulses.
5. ACTIVE_HIGH=0, NUM_ROWS=8, SYNC_STAGES=3, DEBOUNCE_CYCLES=4; row=8'hFF then row[5]=0 -> row_stable=8'h20 at edge 7, row_idx=5, press_pulse 1 cycle.
6. Row[3] held; reset asserted for 1 cycle at count 10 -> outputs 0, no release_pulse; row_stable[3] returns 18 edges after reset deasserts, with press_pulse.

Source files
------------

// File: rtl/keypad_row_debouncer.sv
// Keypad row conditioner: per-row synchronizer chain and debounce counter, followed by
// combinational decodes of the accepted row vector and press/release edge pulses.
module keypad_row_debouncer #(
   parameter int unsigned NUM_ROWS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter bit          ACTIVE_HIGH     = 1'b1,
   localparam int unsigned IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_ROWS-1:0] row_stable,
   output logic                key_active,
   output logic [IDX_W-1:0]    row_idx,
   output logic                multi_row,
   output logic                press_pulse,
   output logic                release_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_ROWS-1:0] rn;
   logic [NUM_ROWS-1:0] sync_q [SYNC_STAGES];
   logic [NUM_ROWS-1:0] sync;
   logic [CNT_W-1:0]    cnt_q  [NUM_ROWS];
   logic [CNT_W-1:0]    cnt_d  [NUM_ROWS];
   logic [NUM_ROWS-1:0] row_stable_q;
   logic [NUM_ROWS-1:0] row_stable_d;
   logic                key_active_q;

   // Everything downstream works in active-high terms.
   assign rn   = ACTIVE_HIGH ? row : ~row;
   assign sync = sync_q[SYNC_STAGES-1];

   // Plain flop chain per row; no logic between stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= rn;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Per-row debounce: count consecutive disagreeing cycles, accept on the last one,
   // and clear the count whenever the synchronized level agrees with the accepted one.
   always_comb begin
      row_stable_d = row_stable_q;
      for (int i = 0; i < NUM_ROWS; i++) begin
         cnt_d[i] = '0;
         if (sync[i] != row_stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               row_stable_d[i] = sync[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Debounce state and key_active history register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ROWS; i++) cnt_q[i] <= '0;
         row_stable_q <= '0;
         key_active_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ROWS; i++) cnt_q[i] <= cnt_d[i];
         row_stable_q <= row_stable_d;
         key_active_q <= key_active;
      end
   end

   // Lowest set bit wins: scan from the top so lower rows overwrite.
   always_comb begin
      row_idx = '0;
      for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
         if (row_stable_q[i]) row_idx = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   always_comb begin
      row_stable    = row_stable_q;
      key_active    = |row_stable_q;
      multi_row     = (row_stable_q & (row_stable_q - NUM_ROWS'(1))) != '0;
      press_pulse   = key_active & ~key_active_q;
      release_pulse = ~key_active & key_active_q;
   end

endmodule
